cdb_arbiter: RTL

// Shares the single common data bus (CDB) between NUM_FU functional units, e.g. ALU, MUL, DIV and LSU.

---
 rtl/riscalar_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/cdb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/riscalar_pkg.sv
// Shared types and widths for the out-of-order core's result path.
package riscalar_pkg;

    // ROB holds 8 entries, so a ROB index is 3 bits wide
    localparam int ROB_IX_W = 3;

    // Result values and destinations share one datapath width
    localparam int DATA_W = 32;

    // One finished result as it travels from a functional unit onto the CDB
    typedef struct packed {
        logic [ROB_IX_W-1:0]      rob_ix;
        logic signed [DATA_W-1:0] value;
        logic [DATA_W-1:0]        dest;
    } cdb_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
// The requests are laid out twice side by side. The lower copy is masked to
// the bits at or above ptr, so the lowest set bit of the double-width vector
// is the first requester found when scanning from ptr with wrap.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int IX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IX_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IX_W-1:0] grant_ix
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_grant;

    // Keep the bits at or above the pointer, then isolate the lowest set bit of the doubled vector
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IX_W'(i) >= ptr);
        end
        dbl       = {req, req & mask};
        dbl_grant = dbl & ~(dbl - (2*N)'(1));
        grant     = dbl_grant[N-1:0] | dbl_grant[2*N-1:N];
    end

    // Turn the one-hot grant into a binary index; an empty grant encodes to 0
    always_comb begin
        grant_ix = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_ix = grant_ix | IX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one finished functional unit per cycle by
// round-robin and registers its result onto the CDB one cycle later.
// A flush withholds the grant for that cycle without moving the pointer.
// Payload widths come from riscalar_pkg; the width parameters must match it.
module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int ROB_IX_W = riscalar_pkg::ROB_IX_W,
    parameter int DATA_W   = riscalar_pkg::DATA_W,
    parameter int SRC_W    = $clog2(NUM_FU)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       flush_in,
    input  logic [NUM_FU-1:0]          req_valid_in,
    input  logic [NUM_FU*ROB_IX_W-1:0] req_rob_ix_in,
    input  logic [NUM_FU*DATA_W-1:0]   req_value_in,
    input  logic [NUM_FU*DATA_W-1:0]   req_dest_in,
    output logic [NUM_FU-1:0]          req_ready_out,
    output logic                       cdb_valid_out,
    output logic [ROB_IX_W-1:0]        cdb_rob_ix_out,
    output logic [DATA_W-1:0]          cdb_value_out,
    output logic [DATA_W-1:0]          cdb_dest_out,
    output logic [SRC_W-1:0]           cdb_src_out
);

    import riscalar_pkg::*;

    localparam logic [SRC_W-1:0] LAST_FU = SRC_W'(NUM_FU - 1);

    cdb_msg_t          req_msg [NUM_FU];
    cdb_msg_t          cdb_msg_q;
    logic              cdb_valid_q;
    logic [SRC_W-1:0]  cdb_src_q;
    logic [SRC_W-1:0]  ptr_q;
    logic [NUM_FU-1:0] arb_req;
    logic [NUM_FU-1:0] grant;
    logic [SRC_W-1:0]  grant_ix;
    logic              any_grant;

    // Slice the flattened request buses into one message per functional unit
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req_msg[i].rob_ix = req_rob_ix_in[i*ROB_IX_W +: ROB_IX_W];
            req_msg[i].value  = req_value_in[i*DATA_W +: DATA_W];
            req_msg[i].dest   = req_dest_in[i*DATA_W +: DATA_W];
        end
    end

    // A flush hides every request so nothing is granted or consumed that cycle
    always_comb begin
        arb_req = flush_in ? '0 : req_valid_in;
    end

    rr_arbiter #(
        .N    (NUM_FU),
        .IX_W (SRC_W)
    ) u_rr_arbiter (
        .req      (arb_req),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_ix (grant_ix)
    );

    // Ready mirrors the grant, but stays low while reset is held
    always_comb begin
        any_grant     = |grant;
        req_ready_out = rst_n_in ? grant : '0;
    end

    // Register the winner onto the CDB and advance the pointer past it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_valid_q <= 1'b0;
            cdb_msg_q   <= '0;
            cdb_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            cdb_valid_q <= any_grant;
            if (any_grant) begin
                cdb_msg_q <= req_msg[grant_ix];
                cdb_src_q <= grant_ix;
                ptr_q     <= (grant_ix == LAST_FU) ? '0 : grant_ix + 1'b1;
            end
        end
    end

    assign cdb_valid_out  = cdb_valid_q;
    assign cdb_rob_ix_out = cdb_msg_q.rob_ix;
    assign cdb_value_out  = cdb_msg_q.value;
    assign cdb_dest_out   = cdb_msg_q.dest;
    assign cdb_src_out    = cdb_src_q;

endmodule
